// File: rtl/doa_smoother_if.sv
// Bundles the weightblock-facing inputs and the readout-facing outputs of doa_smoother.
// The master modport drives the inputs; the slave modport is the smoother itself.
interface doa_smoother_if #(
  parameter int LOG2_DEPTH = 2
);
  logic                done;
  logic [5:0]          bnum;
  logic [7:0]          doa;
  logic                clear;
  logic [7:0]          avg_doa;
  logic [5:0]          last_bnum;
  logic                avg_valid;
  logic                upd;
  logic [LOG2_DEPTH:0] nsamp;
  logic                ovr;
  logic                reject;

  modport master (
    output done, bnum, doa, clear,
    input  avg_doa, last_bnum, avg_valid, upd, nsamp, ovr, reject
  );

  modport slave (
    input  done, bnum, doa, clear,
    output avg_doa, last_bnum, avg_valid, upd, nsamp, ovr, reject
  );
endinterface

// File: rtl/doa_smoother.sv
// Rounded moving average over the last 2**LOG2_DEPTH DOA estimates from weightblock.
// Optional outlier substitution is compiled in with `define DOA_OUTLIER_EN.
module doa_smoother #(
  parameter int LOG2_DEPTH     = 2,
  parameter int OUTLIER_THRESH = 30
) (
  input  logic           clk,
  input  logic           reset,
  doa_smoother_if.slave  bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 8 + LOG2_DEPTH + 1;
  localparam int NW    = LOG2_DEPTH + 1;
  localparam logic [NW-1:0] FULL   = NW'(DEPTH);
  localparam logic [7:0]    THRESH = 8'(OUTLIER_THRESH);

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, OUTPUT} state_t;

  state_t                state_reg;
  logic [7:0]            hist [DEPTH];
  logic [LOG2_DEPTH-1:0] wp_reg;
  logic [SW-1:0]         sum_reg;
  logic [NW-1:0]         nsamp_reg;
  logic [7:0]            d_reg;
  logic [5:0]            b_reg;
  logic [7:0]            old_reg;
  logic [7:0]            avg_reg;
  logic [5:0]            last_bnum_reg;
  logic                  avg_valid_reg;
  logic                  upd_reg;
  logic                  ovr_reg;
  logic                  reject_reg;

  logic [SW-1:0]         rounded;
  logic [NW-1:0]         nsamp_next;

  assign rounded    = sum_reg + SW'(DEPTH / 2);
  assign nsamp_next = (nsamp_reg == FULL) ? FULL : nsamp_reg + NW'(1);

`ifdef DOA_OUTLIER_EN
  logic [7:0] diff;
  assign diff = (d_reg >= avg_reg) ? (d_reg - avg_reg) : (avg_reg - d_reg);
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  // History storage carries no reset: nsamp gates whether an entry is ever read.
  always_ff @(posedge clk) begin
    if (state_reg == UPDATE && !bus.clear)
      hist[wp_reg] <= d_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wp_reg        <= '0;
      sum_reg       <= '0;
      nsamp_reg     <= '0;
      d_reg         <= '0;
      b_reg         <= '0;
      old_reg       <= '0;
      avg_reg       <= '0;
      last_bnum_reg <= '0;
      avg_valid_reg <= 1'b0;
      upd_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
      reject_reg    <= 1'b0;
    end else begin
      upd_reg    <= 1'b0;
      reject_reg <= 1'b0;
      if (bus.clear) begin
        // avg_doa and last_bnum deliberately keep their last values across a flush
        state_reg     <= IDLE;
        sum_reg       <= '0;
        wp_reg        <= '0;
        nsamp_reg     <= '0;
        avg_valid_reg <= 1'b0;
        ovr_reg       <= 1'b0;
      end else begin
        if (bus.done && state_reg != IDLE)
          ovr_reg <= 1'b1;
        case (state_reg)
          IDLE: begin
            if (bus.done) begin
              d_reg     <= bus.doa;
              b_reg     <= bus.bnum;
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            old_reg <= (nsamp_reg == FULL) ? hist[wp_reg] : 8'd0;
`ifdef DOA_OUTLIER_EN
            if (avg_valid_reg && diff > THRESH) begin
              d_reg      <= avg_reg;
              reject_reg <= 1'b1;
            end
`endif
            state_reg <= UPDATE;
          end
          UPDATE: begin
            sum_reg   <= sum_reg + SW'(d_reg) - SW'(old_reg);
            wp_reg    <= wp_reg + LOG2_DEPTH'(1);
            nsamp_reg <= nsamp_next;
            state_reg <= OUTPUT;
          end
          OUTPUT: begin
            if (nsamp_reg == FULL) begin
              avg_reg       <= rounded[LOG2_DEPTH +: 8];
              avg_valid_reg <= 1'b1;
            end
            last_bnum_reg <= b_reg;
            upd_reg       <= 1'b1;
            state_reg     <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.avg_doa   = avg_reg;
  assign bus.last_bnum = last_bnum_reg;
  assign bus.avg_valid = avg_valid_reg;
  assign bus.upd       = upd_reg;
  assign bus.nsamp     = nsamp_reg;
  assign bus.ovr       = ovr_reg;
  assign bus.reject    = reject_reg;
endmodule

// File: tb/tb_doa_smoother.sv
// Scoreboard bench for doa_smoother: a queue-based history model predicts each upd pulse.
// Build with +define+DOA_OUTLIER_EN to exercise outlier substitution.
module tb_doa_smoother;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH      = 1 << LOG2_DEPTH;
  localparam int THRESH     = 30;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  doa_smoother_if #(.LOG2_DEPTH(LOG2_DEPTH)) ifc ();

  doa_smoother #(.LOG2_DEPTH(LOG2_DEPTH), .OUTLIER_THRESH(THRESH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int avg;
    int bnum;
    int nsamp;
    int valid;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hist_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_avg    = 0;
  int   m_ovr    = 0;
  int   busy     = 0;
  int   prev_avg = 0;
  int   pend_rej = 0;
  int   exp_rej  = 0;
  int   rej_seen = 0;
  int   upd_seen = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model for an accepted sample: plain average of the newest DEPTH values.
  task automatic accept(int v, int b);
    int   d;
    int   sum;
    exp_t e;
    d        = v;
    pend_rej = 0;
    prev_avg = m_avg;
`ifdef DOA_OUTLIER_EN
    if (hist_q.size() == DEPTH) begin
      int diff;
      diff = (d > m_avg) ? d - m_avg : m_avg - d;
      if (diff > THRESH) begin
        d = m_avg;
        exp_rej++;
        pend_rej = 1;
      end
    end
`endif
    hist_q.push_back(d);
    if (hist_q.size() > DEPTH) hist_q.delete(0);
    if (hist_q.size() == DEPTH) begin
      sum = 0;
      foreach (hist_q[i]) sum += hist_q[i];
      m_avg = (sum + DEPTH / 2) / DEPTH;
    end
    e.avg   = m_avg;
    e.bnum  = b;
    e.nsamp = hist_q.size();
    e.valid = (hist_q.size() == DEPTH) ? 1 : 0;
    e.cyc   = cyc + 3;
    exp_q.push_back(e);
    busy = 3;
    $display("stim: doa=%0d bnum=%0d accepted, model avg=%0d nsamp=%0d", v, b, e.avg, e.nsamp);
  endtask

  // One clock of stimulus; the model tracks which edges see the DUT busy.
  task automatic step(bit d, int v, int b, bit c);
    ifc.done  = d;
    ifc.doa   = 8'(v);
    ifc.bnum  = 6'(b);
    ifc.clear = c;
    @(posedge clk);
    #1;
    ifc.done  = 1'b0;
    ifc.clear = 1'b0;
    if (c) begin
      if (busy > 0) begin
        exp_q.delete(exp_q.size() - 1);
        m_avg = prev_avg;
        if (pend_rej != 0 && busy == 3) exp_rej--;
      end
      hist_q.delete();
      m_ovr = 0;
      busy  = 0;
      $display("stim: clear (done=%0d)", d);
    end else if (d) begin
      if (busy > 0) begin
        m_ovr = 1;
        busy--;
        $display("stim: doa=%0d bnum=%0d dropped while busy", v, b);
      end else begin
        accept(v, b);
      end
    end else if (busy > 0) begin
      busy--;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (ifc.reject) rej_seen++;
      if (ifc.upd) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_upd", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("upd: avg=%0d bnum=%0d nsamp=%0d valid=%0d", ifc.avg_doa, ifc.last_bnum,
                   ifc.nsamp, ifc.avg_valid);
          chk("upd_latency", cyc, e.cyc);
          chk("avg_doa", int'(ifc.avg_doa), e.avg);
          chk("last_bnum", int'(ifc.last_bnum), e.bnum);
          chk("nsamp", int'(ifc.nsamp), e.nsamp);
          chk("avg_valid", int'(ifc.avg_valid), e.valid);
        end
      end
    end
  end

  initial begin
    int gap;
    reset     = 1'b1;
    ifc.done  = 1'b0;
    ifc.doa   = '0;
    ifc.bnum  = '0;
    ifc.clear = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_avg_doa", int'(ifc.avg_doa), 0);
    chk("rst_last_bnum", int'(ifc.last_bnum), 0);
    chk("rst_avg_valid", int'(ifc.avg_valid), 0);
    chk("rst_upd", int'(ifc.upd), 0);
    chk("rst_nsamp", int'(ifc.nsamp), 0);
    chk("rst_ovr", int'(ifc.ovr), 0);
    chk("rst_reject", int'(ifc.reject), 0);
    idle(20);
    chk("idle_no_upd", upd_seen, 0);

    // Fill the history: 10,20,30,40.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 10 * (i + 1), 3 + i, 1'b0);
      idle(9);
      chk("fill_nsamp", int'(ifc.nsamp), i + 1);
      chk("fill_valid", int'(ifc.avg_valid), (i == 3) ? 1 : 0);
    end
    chk("fill_avg", int'(ifc.avg_doa), 25);
    chk("fill_bnum", int'(ifc.last_bnum), 6);

    // Wrap: 50 overwrites 10.
    step(1'b1, 50, 7, 1'b0);
    idle(9);
    chk("wrap_avg", int'(ifc.avg_doa), 35);
    chk("wrap_nsamp", int'(ifc.nsamp), 4);

    // Back-to-back done: second one is dropped.
    step(1'b1, 60, 8, 1'b0);
    step(1'b1, 70, 9, 1'b0);
    idle(9);
    chk("drop_ovr", int'(ifc.ovr), 1);
    chk("drop_avg", int'(ifc.avg_doa), 45);

    // Clear lands while the pending sample is in UPDATE.
    step(1'b1, 77, 10, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    chk("clr_valid", int'(ifc.avg_valid), 0);
    chk("clr_nsamp", int'(ifc.nsamp), 0);
    chk("clr_ovr", int'(ifc.ovr), 0);
    idle(6);
    chk("clr_avg_hold", int'(ifc.avg_doa), 45);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 90, 11 + i, 1'b0);
      idle(5);
    end
    chk("refill_avg", int'(ifc.avg_doa), 90);
    chk("refill_valid", int'(ifc.avg_valid), 1);

    step(1'b1, 200, 20, 1'b0);
    idle(6);
`ifdef DOA_OUTLIER_EN
    chk("outlier_avg", int'(ifc.avg_doa), 90);
    chk("outlier_rejects", rej_seen, 1);
`else
    chk("outlier_avg", int'(ifc.avg_doa), 118);
    chk("outlier_rejects", rej_seen, 0);
`endif
    chk("outlier_bnum", int'(ifc.last_bnum), 20);

    // Randomized traffic: variable gaps (some too short), occasional clears.
    for (int i = 0; i < 120; i++) begin
      gap = $urandom_range(0, 5);
      idle(gap);
      if ($urandom_range(0, 14) == 0)
        step($urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 63), 1'b1);
      else if ($urandom_range(0, 3) == 0)
        step(1'b1, m_avg + $urandom_range(0, 20) - 10 < 0 ? 0 : m_avg, $urandom_range(0, 63), 1'b0);
      else
        step(1'b1, $urandom_range(0, 255), $urandom_range(0, 63), 1'b0);
    end

    idle(10);
    chk("drain_empty", exp_q.size(), 0);
    chk("final_ovr", int'(ifc.ovr), m_ovr);
    chk("final_nsamp", int'(ifc.nsamp), hist_q.size());
    chk("final_valid", int'(ifc.avg_valid), (hist_q.size() == DEPTH) ? 1 : 0);
    chk("final_avg", int'(ifc.avg_doa), m_avg);
    chk("reject_count", rej_seen, exp_rej);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
